// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
//   owner_t    : which requester owns the response slot of the access in flight
//   WAIT_CNT_W : width of the fetch starvation counter
package mem_arb_pkg;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation guard for mem_bus_arbiter.
// Counts consecutive cycles in which fetch requested and was not granted,
// saturating at MAX_WAIT. force_if is high while the count sits at MAX_WAIT,
// which hands the next contended cycle to fetch.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   if_req    : fetch request
//   if_gnt    : fetch grant issued this cycle
//   force_if  : fetch must win arbitration this cycle
module mem_arb_starve_ctr #(
   parameter int MAX_WAIT = 4   // legal range 1..15
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic if_gnt,
   output logic force_if
);
   import mem_arb_pkg::*;

   localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   // Any cycle that is not a denied fetch request (granted, idle, or the
   // request withdrawn early) restarts the count.
   always_comb begin
      wait_cnt_d = '0;
      if (if_req && !if_gnt) begin
         wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign force_if = (wait_cnt_q == MAX_WAIT_C);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one single-port synchronous memory between the
// instruction-fetch (IF) port and the load/store (LS) port. One access per
// cycle; read data is routed back to its owner exactly one cycle after grant.
// LS has priority unless fetch has been denied MAX_WAIT cycles in a row.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt         : fetch request and combinational grant
//   if_rvalid/if_rdata               : fetch response, cycle after grant
//   ls_req/ls_we/ls_addr/ls_wdata/ls_wmask -> ls_gnt : load/store request, grant
//   ls_rvalid/ls_rdata               : load data or store ack (data 0)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wmask, mem_rdata : memory port
// Optional build macro MEM_ARB_STATS_EN adds free-running 32-bit counters
// stat_if_gnt, stat_ls_gnt (grants per port) and stat_conflict (cycles with
// both requests high).
module mem_bus_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,   // multiple of 8
   parameter int MAX_WAIT = 4     // legal range 1..15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wmask,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]         stat_if_gnt,
   output logic [31:0]         stat_ls_gnt,
   output logic [31:0]         stat_conflict
`endif
);
   import mem_arb_pkg::*;

   logic   force_if;
   owner_t owner_q, owner_d;
   logic   store_q, store_d;

   mem_arb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_ctr (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_gnt   (if_gnt),
      .force_if (force_if)
   );

   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (!rst) begin
         if (if_req && (!ls_req || force_if)) begin
            if_gnt = 1'b1;
         end else if (ls_req) begin
            ls_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      mem_en    = if_gnt | ls_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (ls_gnt) begin
         mem_we    = ls_we;
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
         mem_wmask = ls_we ? ls_wmask : '0;
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (if_gnt) begin
         owner_d = OWN_IF;
      end else if (ls_gnt) begin
         owner_d = OWN_LS;
      end
      store_d = ls_gnt & ls_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_NONE;
         store_q <= 1'b0;
      end else begin
         owner_q <= owner_d;
         store_q <= store_d;
      end
   end

   // Responses are also gated by rst so an access granted just before reset
   // never produces an rvalid while reset is asserted.
   always_comb begin
      if_rvalid = 1'b0;
      if_rdata  = '0;
      ls_rvalid = 1'b0;
      ls_rdata  = '0;
      if (!rst) begin
         case (owner_q)
            OWN_IF: begin
               if_rvalid = 1'b1;
               if_rdata  = mem_rdata;
            end
            OWN_LS: begin
               ls_rvalid = 1'b1;
               ls_rdata  = store_q ? '0 : mem_rdata;
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_if_gnt_q, stat_if_gnt_d;
   logic [31:0] stat_ls_gnt_q, stat_ls_gnt_d;
   logic [31:0] stat_conflict_q, stat_conflict_d;

   always_comb begin
      stat_if_gnt_d   = stat_if_gnt_q + {31'd0, if_gnt};
      stat_ls_gnt_d   = stat_ls_gnt_q + {31'd0, ls_gnt};
      stat_conflict_d = stat_conflict_q + {31'd0, (if_req & ls_req)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_if_gnt_q   <= '0;
         stat_ls_gnt_q   <= '0;
         stat_conflict_q <= '0;
      end else begin
         stat_if_gnt_q   <= stat_if_gnt_d;
         stat_ls_gnt_q   <= stat_ls_gnt_d;
         stat_conflict_q <= stat_conflict_d;
      end
   end

   assign stat_if_gnt   = stat_if_gnt_q;
   assign stat_ls_gnt   = stat_ls_gnt_q;
   assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters on the soc.
  - The core's instruction-fetch (IF) port.
  - The load/store (LS) port.
- Issues at most one memory access per cycle and routes the read data back to the requester that owns it, one cycle later.
- Sits between riscv and the memory in soc.
- LS has priority, except that a starvation guard guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_WAIT, 4, consecutive cycles IF may be denied before it gets forced priority; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid (cycle after if_gnt).
- if_rdata  out  DATA_W  fetch data.
- ls_req  in  1  load/store request; held with all ls_* fields stable until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  data address.
- ls_wdata  in  DATA_W  store data.
- ls_wmask  in  DATA_W/8  store byte enables.
- ls_gnt  out  1  load/store accepted this cycle (combinational).
- ls_rvalid  out  1  load data valid / store acknowledge (cycle after ls_gnt).
- ls_rdata  out  DATA_W  load data; 0 for store acks.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset values:
  - if_rvalid, ls_rvalid = 0; if_rdata, ls_rdata = 0.
  - Owner register = OWN_NONE; wait counter = 0.
- While rst is high, if_gnt, ls_gnt and mem_en are forced to 0.
- Grant select (combinational, every cycle):
  - Only ls_req: grant LS.
  - Only if_req: grant IF.
  - Both: grant LS, unless wait_cnt == MAX_WAIT, in which case grant IF.
  - Exactly one gnt may be high per cycle; mem_en = if_gnt | ls_gnt.
- Memory command:
  - IF grant: mem_we = 0, mem_addr = if_addr, mem_wmask = 0.
  - LS grant: mem_we = ls_we, mem_addr = ls_addr, mem_wdata = ls_wdata, mem_wmask = ls_wmask if ls_we, else 0.
  - No grant: mem_en = 0, and mem_we, mem_addr, mem_wdata, mem_wmask are all driven 0.
- Wait counter (4-bit):
  - if_req & !if_gnt: increment, saturating at MAX_WAIT.
  - Otherwise: clear to 0.
- Response path:
  - The owner register captures {OWN_IF, OWN_LS, OWN_NONE} and the store flag at each posedge.
  - Next cycle:
    - OWN_IF: if_rvalid = 1, if_rdata = mem_rdata.
    - OWN_LS load: ls_rvalid = 1, ls_rdata = mem_rdata.
    - OWN_LS store: ls_rvalid = 1, ls_rdata = 0.
  - Latency: gnt at cycle N gives rvalid at N+1, fixed.
  - Fully pipelined: back-to-back grants every cycle, to the same or alternating ports.
- Boundary conditions:
  - A requester must not deassert req before gnt. Deassertion before gnt is tolerated with no side effects, and the wait counter clears.
  - Simultaneous rvalid (N+1) and new gnt (N+1) are legal and independent.
  - Reset mid-access: a pending response is dropped and no rvalid appears after reset; the wait counter clears.
  - MAX_WAIT = 1: IF waits at most 1 cycle under continuous LS traffic, giving strict alternation.
  - Addresses are passed through unmodified; there is no alignment checking.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds three 32-bit outputs, stat_if_gnt, stat_ls_gnt and stat_conflict.
  - stat_if_gnt and stat_ls_gnt count grants to each port.
  - stat_conflict counts cycles with if_req & ls_req.
  - All three reset to 0 on rst and wrap modulo 2^32.
  - The tb reads them with $display at end of test.
- Undefined: those ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - owner_t enum {OWN_NONE, OWN_IF, OWN_LS}.
  - WAIT_CNT_W = 4.
- One natural sub-module: mem_arb_starve_ctr. It holds the saturating wait counter and its force_if output (wait_cnt == MAX_WAIT).
- Grant mux and response routing stay in mem_bus_arbiter.

Test Plan:
- IF only, if_addr = 0x0, 0x4, 0x8 on consecutive cycles with memory preloaded → if_gnt high each cycle; if_rvalid on cycles 2..4 with matching words; ls_rvalid always 0.
- Store then load to the same address:
  - Stimulus: ls_we = 1, ls_addr = 0x100, ls_wdata = 0xDEADBEEF, ls_wmask = 0xF; then load 0x100.
  - Response: ls_rvalid with ls_rdata = 0 for the store ack, then ls_rdata = 0xDEADBEEF.
- Both requesting continuously, MAX_WAIT = 4 → grant pattern LS,LS,LS,LS,IF repeating; if_gnt never waits more than 4 cycles.
- Byte-masked store ls_wmask = 0x2, ls_wdata = 0x0000AB00 over 0x11223344 → reload returns 0x1122AB44.
- rst asserted the cycle after an ls_gnt load → no ls_rvalid after reset; all outputs 0; wait counter 0.
- With MEM_ARB_STATS_EN: 10 cycles of both requesting, MAX_WAIT = 4 → stat_ls_gnt = 8, stat_if_gnt = 2, stat_conflict = 10.
